// File: rtl/wb_queue.sv
// Writeback queue: merges load and ALU results in order and drains one per
// cycle onto the register file write port, with bypass lookups for the reads.
module wb_queue #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_data,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            we3,
    output logic [4:0]      wa3,
    output logic [XLEN-1:0] wd3,
    input  logic [4:0]      ra1,
    input  logic [4:0]      ra2,
    output logic            byp1_hit,
    output logic [XLEN-1:0] byp1_data,
    output logic            byp2_hit,
    output logic [XLEN-1:0] byp2_data,
    output logic [CW-1:0]   count,
    output logic            full,
    output logic            empty
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned RW = 5;

    logic [RW-1:0]   rd_q   [DEPTH];
    logic [XLEN-1:0] data_q [DEPTH];

    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic            we3_q, we3_d;
    logic [RW-1:0]   wa3_q, wa3_d;
    logic [XLEN-1:0] wd3_q, wd3_d;

    logic            mem_push;
    logic            alu_push;
    logic            pop;
    logic [PW-1:0]   alu_slot;

    // Ready looks only at registered occupancy; a same-cycle pop frees nothing.
    always_comb begin
        mem_ready = !rst && (count_q < CW'(DEPTH));
        alu_ready = !rst &&
                    (({1'b0, count_q} + (CW+1)'(mem_valid)) < (CW+1)'(DEPTH));
    end

    // x0 results complete the handshake but are never stored.
    always_comb begin
        mem_push = mem_valid && mem_ready && (mem_rd != '0);
        alu_push = alu_valid && alu_ready && (alu_rd != '0);
        pop      = (count_q != '0);
        alu_slot = tail_q + PW'(mem_push);
    end

    always_comb begin
        head_d  = pop ? head_q + PW'(1) : head_q;
        tail_d  = tail_q + PW'(mem_push) + PW'(alu_push);
        count_d = count_q + CW'(mem_push) + CW'(alu_push) - CW'(pop);
        we3_d   = pop;
        wa3_d   = wa3_q;
        wd3_d   = wd3_q;
        if (pop) begin
            wa3_d = rd_q[head_q];
            wd3_d = data_q[head_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            we3_q   <= 1'b0;
            wa3_q   <= '0;
            wd3_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            we3_q   <= we3_d;
            wa3_q   <= wa3_d;
            wd3_q   <= wd3_d;
        end
    end

    // Mem entry takes the tail slot first so it is older than a same-cycle ALU entry.
    always_ff @(posedge clk) begin
        if (mem_push) begin
            rd_q[tail_q]   <= mem_rd;
            data_q[tail_q] <= mem_data;
        end
        if (alu_push) begin
            rd_q[alu_slot]   <= alu_rd;
            data_q[alu_slot] <= alu_data;
        end
    end

    // Scan oldest to youngest so the last match (youngest) wins.
    always_comb begin
        byp1_hit  = 1'b0;
        byp1_data = '0;
        byp2_hit  = 1'b0;
        byp2_data = '0;
        if (we3_q && (wa3_q == ra1)) begin
            byp1_hit  = 1'b1;
            byp1_data = wd3_q;
        end
        if (we3_q && (wa3_q == ra2)) begin
            byp2_hit  = 1'b1;
            byp2_data = wd3_q;
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < count_q) && (rd_q[head_q + PW'(i)] == ra1)) begin
                byp1_hit  = 1'b1;
                byp1_data = data_q[head_q + PW'(i)];
            end
            if ((CW'(i) < count_q) && (rd_q[head_q + PW'(i)] == ra2)) begin
                byp2_hit  = 1'b1;
                byp2_data = data_q[head_q + PW'(i)];
            end
        end
        if (ra1 == '0) begin
            byp1_hit  = 1'b0;
            byp1_data = '0;
        end
        if (ra2 == '0) begin
            byp2_hit  = 1'b0;
            byp2_data = '0;
        end
    end

    always_comb begin
        we3   = we3_q;
        wa3   = wa3_q;
        wd3   = wd3_q;
        count = count_q;
        full  = (count_q == CW'(DEPTH));
        empty = (count_q == '0);
    end

endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue: per-cycle vector table plus sequences for
// backpressure with a scoreboard and reset in the middle of traffic.
module tb_wb_queue;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 3;

    logic            clk;
    logic            rst;
    logic            mem_valid, mem_ready;
    logic [4:0]      mem_rd;
    logic [XLEN-1:0] mem_data;
    logic            alu_valid, alu_ready;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            we3;
    logic [4:0]      wa3;
    logic [XLEN-1:0] wd3;
    logic [4:0]      ra1, ra2;
    logic            byp1_hit, byp2_hit;
    logic [XLEN-1:0] byp1_data, byp2_data;
    logic [CW-1:0]   count;
    logic            full, empty;

    int checks   = 0;
    int failures = 0;

    wb_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .we3(we3), .wa3(wa3), .wd3(wd3),
        .ra1(ra1), .ra2(ra2),
        .byp1_hit(byp1_hit), .byp1_data(byp1_data),
        .byp2_hit(byp2_hit), .byp2_data(byp2_data),
        .count(count), .full(full), .empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] md;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic        e_mr;
        logic        e_ar;
        logic        e_we;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic [2:0]  e_cnt;
        logic        e_h1;
        logic [31:0] e_d1;
        logic        e_h2;
        logic [31:0] e_d2;
    } vec_t;

    vec_t tbl [11];

    int              mc;
    logic            pop_now;
    logic            e_mr, e_ar;
    logic [36:0]     sb [$];
    logic [36:0]     ent;

    initial begin
        // Each row: inputs for one cycle and the outputs expected before that edge.
        tbl[0]  = '{1'b0, 5'd0, 32'h0,  1'b1, 5'd5, 32'hAA, 5'd5, 5'd0,
                    1'b1, 1'b1, 1'b0, 5'd0, 32'h0,  3'd0, 1'b0, 32'h0,  1'b0, 32'h0};
        tbl[1]  = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd5, 5'd0,
                    1'b1, 1'b1, 1'b0, 5'd0, 32'h0,  3'd1, 1'b1, 32'hAA, 1'b0, 32'h0};
        tbl[2]  = '{1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 5'd5, 5'd4,
                    1'b1, 1'b1, 1'b1, 5'd5, 32'hAA, 3'd0, 1'b1, 32'hAA, 1'b0, 32'h0};
        tbl[3]  = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd3, 5'd4,
                    1'b1, 1'b1, 1'b0, 5'd5, 32'hAA, 3'd2, 1'b1, 32'h11, 1'b1, 32'h22};
        tbl[4]  = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd3, 5'd4,
                    1'b1, 1'b1, 1'b1, 5'd3, 32'h11, 3'd1, 1'b1, 32'h11, 1'b1, 32'h22};
        tbl[5]  = '{1'b0, 5'd0, 32'h0,  1'b1, 5'd0, 32'h55, 5'd4, 5'd0,
                    1'b1, 1'b1, 1'b1, 5'd4, 32'h22, 3'd0, 1'b1, 32'h22, 1'b0, 32'h0};
        tbl[6]  = '{1'b0, 5'd0, 32'h0,  1'b1, 5'd7, 32'h1,  5'd7, 5'd0,
                    1'b1, 1'b1, 1'b0, 5'd4, 32'h22, 3'd0, 1'b0, 32'h0,  1'b0, 32'h0};
        tbl[7]  = '{1'b0, 5'd0, 32'h0,  1'b1, 5'd7, 32'h2,  5'd7, 5'd0,
                    1'b1, 1'b1, 1'b0, 5'd4, 32'h22, 3'd1, 1'b1, 32'h1,  1'b0, 32'h0};
        tbl[8]  = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd7, 5'd0,
                    1'b1, 1'b1, 1'b1, 5'd7, 32'h1,  3'd1, 1'b1, 32'h2,  1'b0, 32'h0};
        tbl[9]  = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd7, 5'd0,
                    1'b1, 1'b1, 1'b1, 5'd7, 32'h2,  3'd0, 1'b1, 32'h2,  1'b0, 32'h0};
        tbl[10] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd7, 5'd0,
                    1'b1, 1'b1, 1'b0, 5'd7, 32'h2,  3'd0, 1'b0, 32'h0,  1'b0, 32'h0};

        rst = 1'b1;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        ra1 = '0; ra2 = '0;

        tick();
        chk("rst_mem_ready", 32'(mem_ready), 32'd0);
        chk("rst_alu_ready", 32'(alu_ready), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("idle_we3",       32'(we3),       32'd0);
        chk("idle_count",     32'(count),     32'd0);
        chk("idle_empty",     32'(empty),     32'd1);
        chk("idle_mem_ready", 32'(mem_ready), 32'd1);
        chk("idle_alu_ready", 32'(alu_ready), 32'd1);

        for (int i = 0; i < 11; i++) begin
            mem_valid = tbl[i].mv; mem_rd = tbl[i].mrd; mem_data = tbl[i].md;
            alu_valid = tbl[i].av; alu_rd = tbl[i].ard; alu_data = tbl[i].ad;
            ra1 = tbl[i].r1; ra2 = tbl[i].r2;
            #1;
            chk($sformatf("v%0d_mem_ready", i), 32'(mem_ready), 32'(tbl[i].e_mr));
            chk($sformatf("v%0d_alu_ready", i), 32'(alu_ready), 32'(tbl[i].e_ar));
            chk($sformatf("v%0d_we3", i),       32'(we3),       32'(tbl[i].e_we));
            chk($sformatf("v%0d_wa3", i),       32'(wa3),       32'(tbl[i].e_wa));
            chk($sformatf("v%0d_wd3", i),       wd3,            tbl[i].e_wd);
            chk($sformatf("v%0d_count", i),     32'(count),     32'(tbl[i].e_cnt));
            chk($sformatf("v%0d_empty", i),     32'(empty),     32'(tbl[i].e_cnt == 3'd0));
            chk($sformatf("v%0d_full", i),      32'(full),      32'(tbl[i].e_cnt == 3'd4));
            chk($sformatf("v%0d_byp1_hit", i),  32'(byp1_hit),  32'(tbl[i].e_h1));
            chk($sformatf("v%0d_byp1_data", i), byp1_data,      tbl[i].e_d1);
            chk($sformatf("v%0d_byp2_hit", i),  32'(byp2_hit),  32'(tbl[i].e_h2));
            chk($sformatf("v%0d_byp2_data", i), byp2_data,      tbl[i].e_d2);
            tick();
        end

        // Saturate both sources while the drain runs; scoreboard keeps acceptance order.
        mem_valid = 1'b0; alu_valid = 1'b0; ra1 = '0; ra2 = '0;
        mc = 0;
        for (int c = 0; c < 12; c++) begin
            mem_valid = 1'b1; mem_rd = 5'(1 + (2 * c) % 30); mem_data = 32'h1000 + 32'(c);
            alu_valid = 1'b1; alu_rd = 5'(2 + (2 * c) % 30); alu_data = 32'h2000 + 32'(c);
            #1;
            e_mr = (mc < 4);
            e_ar = ((mc + 1) < 4);
            chk("bp_mem_ready", 32'(mem_ready), 32'(e_mr));
            chk("bp_alu_ready", 32'(alu_ready), 32'(e_ar));
            chk("bp_count",     32'(count),     32'(mc));
            chk("bp_full",      32'(full),      32'(mc == 4));
            if (mc == 3) chk("bp_alu_ready_at_3", 32'(alu_ready), 32'd0);
            pop_now = (mc > 0);
            if (e_mr) sb.push_back({mem_rd, mem_data});
            if (e_ar) sb.push_back({alu_rd, alu_data});
            tick();
            if (pop_now) begin
                ent = sb.pop_front();
                chk("bp_we3", 32'(we3), 32'd1);
                chk("bp_wa3", 32'(wa3), 32'(ent[36:32]));
                chk("bp_wd3", wd3,      ent[31:0]);
            end else begin
                chk("bp_we3_idle", 32'(we3), 32'd0);
            end
            mc = mc + (e_mr ? 1 : 0) + (e_ar ? 1 : 0) - (pop_now ? 1 : 0);
            chk("bp_count_le_depth", 32'(count <= CW'(DEPTH)), 32'd1);
        end
        mem_valid = 1'b0; alu_valid = 1'b0;
        for (int k = 0; k < 10 && mc > 0; k++) begin
            tick();
            ent = sb.pop_front();
            chk("dr_we3", 32'(we3), 32'd1);
            chk("dr_wa3", 32'(wa3), 32'(ent[36:32]));
            chk("dr_wd3", wd3,      ent[31:0]);
            mc--;
        end
        chk("dr_count_zero", 32'(count),     32'd0);
        chk("dr_sb_left",    32'(sb.size()), 32'd0);
        tick();
        chk("dr_we3_off", 32'(we3), 32'd0);

        // Reset in the middle of traffic discards queued and in-flight entries.
        mem_valid = 1'b1; mem_rd = 5'd10; mem_data = 32'hA0;
        alu_valid = 1'b1; alu_rd = 5'd11; alu_data = 32'hA1;
        tick();
        chk("mr_count_a", 32'(count), 32'd2);
        mem_rd = 5'd12; mem_data = 32'hA2;
        alu_rd = 5'd13; alu_data = 32'hA3;
        tick();
        mem_valid = 1'b0; alu_valid = 1'b0;
        #1;
        chk("mr_count_b", 32'(count), 32'd3);
        chk("mr_we3_b",   32'(we3),   32'd1);
        chk("mr_wa3_b",   32'(wa3),   32'd10);
        rst = 1'b1;
        mem_valid = 1'b1; mem_rd = 5'd14; mem_data = 32'hB0;
        alu_valid = 1'b1; alu_rd = 5'd15; alu_data = 32'hB1;
        #1;
        chk("mr_rst_mem_ready", 32'(mem_ready), 32'd0);
        chk("mr_rst_alu_ready", 32'(alu_ready), 32'd0);
        tick();
        rst = 1'b0;
        mem_valid = 1'b0; alu_valid = 1'b0;
        #1;
        chk("mr_count_rst", 32'(count), 32'd0);
        chk("mr_we3_rst",   32'(we3),   32'd0);
        chk("mr_wa3_rst",   32'(wa3),   32'd0);
        chk("mr_wd3_rst",   wd3,        32'd0);
        chk("mr_empty_rst", 32'(empty), 32'd1);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("mr_no_write", 32'(we3),   32'd0);
            chk("mr_count",    32'(count), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_queue.md
Name: wb_queue

Overview:
- Write-side initiator for the three-ported register file. It accepts writeback results from the ALU and load paths over valid/ready handshakes and buffers them in order in a small queue.
- It drains one entry per cycle onto the register file write port (we3/wa3/wd3).
- It provides combinational bypass lookups so the read ports never see stale data while writes are still pending.

Parameters:
- XLEN, 32, data width of results and register file words
- DEPTH, 4, queue entries; power of two, >= 2
- CW, $clog2(DEPTH+1), width of the occupancy count

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous active-high reset
- mem_valid  input  1  load result offered
- mem_ready  output  1  load result accepted this cycle
- mem_rd  input  5  load destination register
- mem_data  input  XLEN  load result
- alu_valid  input  1  ALU result offered
- alu_ready  output  1  ALU result accepted this cycle
- alu_rd  input  5  ALU destination register
- alu_data  input  XLEN  ALU result
- we3  output  1  register file write enable (registered)
- wa3  output  5  register file write address (registered)
- wd3  output  XLEN  register file write data (registered)
- ra1  input  5  read port 1 address for bypass lookup
- ra2  input  5  read port 2 address for bypass lookup
- byp1_hit  output  1  a pending write targets ra1
- byp1_data  output  XLEN  youngest pending data for ra1
- byp2_hit  output  1  a pending write targets ra2
- byp2_data  output  XLEN  youngest pending data for ra2
- count  output  CW  queue occupancy; excludes the output register
- full  output  1  count == DEPTH
- empty  output  1  count == 0

Behaviour:
- Reset: rst=1 at a rising edge clears the pointers, sets count=0, we3=0, wa3=0, wd3=0. This applies mid-operation too: queued and in-flight entries are discarded. While rst=1, mem_ready=alu_ready=0.
- Ready is based only on the registered count; a same-cycle dequeue does not free space.
  - mem_ready = (count < DEPTH).
  - alu_ready = (count + (mem_valid ? 1 : 0) < DEPTH).
- Transfer: a source transfers when valid && ready are both high at a rising edge.
- Ordering: if both sources transfer in the same cycle, the mem entry is enqueued first (older) and the alu entry second.
- x0 writes: a transfer with rd == 0 is accepted (ready behaves normally) but not stored; count is unaffected by it.
- Drain, at each rising edge:
  - If count > 0, pop the head into the output registers: we3=1, wa3=head.rd, wd3=head.data.
  - Otherwise we3=0; wa3 and wd3 hold their previous values.
- Push and pop may occur in the same edge. count_next = count + pushes - pop, range 0..DEPTH. Pointers wrap modulo DEPTH.
- Latency: a result accepted at edge N is popped at edge N+1 at the earliest (we3=1 in the following cycle) and written into the register file at edge N+2.
- Bypass (combinational):
  - Search set: all valid queue entries plus the output register when we3=1.
  - Priority: youngest match wins; queue entries are younger than the output register, and the tail is the youngest queue entry.
  - ra == 0 never hits. On a miss, bypass data = 0.
- full/empty are derived combinationally from count.
- Sequential state: pointers, count, storage array, output registers. Ready, bypass and flags are combinational from that state and the inputs.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then 0 -> we3=0, count=0, empty=1, mem_ready=alu_ready=1 on the first non-reset cycle; both readys are 0 while rst=1.
- Single ALU write: alu_rd=5, alu_data=0x0000_00AA accepted at edge N -> count=1 after N; at edge N+1 we3=1, wa3=5, wd3=0xAA; count=0.
- Simultaneous sources: mem(rd=3, 0x11) and alu(rd=4, 0x22) in the same cycle -> drained in order: wa3=3/wd3=0x11, then next cycle wa3=4/wd3=0x22.
- Backpressure with DEPTH=4, drain active:
  - Saturate by offering both sources every cycle with distinct rd values.
  - count must never exceed 4; with count=3 and mem_valid=1, alu_ready=0.
  - Every accepted entry appears exactly once on wa3/wd3, in acceptance order.
- x0 and bypass:
  - alu_rd=0 accepted -> count unchanged, never seen on the write port.
  - Enqueue rd=7 0x1 then rd=7 0x2 with ra1=7 -> byp1_hit=1, byp1_data=0x2 until the second entry writes; ra2=0 -> byp2_hit=0.
- Reset mid-operation: queue 3 entries, assert rst for one edge -> count=0, we3=0 next cycle, no further writes from the discarded entries.
